// File: rtl/agex_stage.sv
// Execute / address-generation stage: registered result one cycle after accept; MUL takes MUL_CYCLES.
// in_ready drops only while the multiplier is busy; memory stage never stalls, so out_* is never held.
package agex_pkg;
  localparam int IOP_W = 6;
  localparam logic [IOP_W-1:0]
    ADD_I   = 6'd0,  SUB_I   = 6'd1,  AND_I   = 6'd2,  OR_I    = 6'd3,
    XOR_I   = 6'd4,  SLT_I   = 6'd5,  SLTU_I  = 6'd6,  SLL_I   = 6'd7,
    SRL_I   = 6'd8,  SRA_I   = 6'd9,  ADDI_I  = 6'd10, ANDI_I  = 6'd11,
    ORI_I   = 6'd12, XORI_I  = 6'd13, SLTI_I  = 6'd14, SLTIU_I = 6'd15,
    SLLI_I  = 6'd16, SRLI_I  = 6'd17, SRAI_I  = 6'd18, LUI_I   = 6'd19,
    AUIPC_I = 6'd20, LW_I    = 6'd21, SW_I    = 6'd22, JAL_I   = 6'd23,
    JALR_I  = 6'd24, BEQ_I   = 6'd25, BNE_I   = 6'd26, BLT_I   = 6'd27,
    BGE_I   = 6'd28, BLTU_I  = 6'd29, BGEU_I  = 6'd30, MUL_I   = 6'd31,
    CSRR_I  = 6'd32, CSRW_I  = 6'd33, INVALID_I = 6'd63;
endpackage

module agex_stage
  import agex_pkg::*;
#(
  parameter int DBITS      = 32,
  parameter int REGNOBITS  = 5,
  parameter int IOPBITS    = IOP_W,
  parameter int MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IOPBITS-1:0]   in_op,
  input  logic [DBITS-1:0]     in_pc,
  input  logic [DBITS-1:0]     in_pcplus,
  input  logic [DBITS-1:0]     in_rs1val,
  input  logic [DBITS-1:0]     in_rs2val,
  input  logic [DBITS-1:0]     in_imm,
  input  logic [REGNOBITS-1:0] in_wregno,
  input  logic [DBITS-1:0]     in_inst_count,
  output logic                 out_valid,
  output logic [DBITS-1:0]     out_result,
  output logic [DBITS-1:0]     out_st_data,
  output logic [REGNOBITS-1:0] out_wregno,
  output logic                 out_wr_reg,
  output logic                 out_is_load,
  output logic                 out_is_store,
  output logic [DBITS-1:0]     out_pc,
  output logic [DBITS-1:0]     out_inst_count,
  output logic                 br_redirect,
  output logic [DBITS-1:0]     br_target
);

  localparam int CNTW = $clog2(MUL_CYCLES);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  typedef struct packed {
    logic                 valid;
    logic [DBITS-1:0]     result;
    logic [DBITS-1:0]     st_data;
    logic [REGNOBITS-1:0] wregno;
    logic                 wr_reg;
    logic                 is_load;
    logic                 is_store;
    logic [DBITS-1:0]     pc;
    logic [DBITS-1:0]     inst_count;
  } exo_t;

  state_t               state, state_nxt;
  logic [CNTW-1:0]      cnt, cnt_nxt;
  logic                 take, is_mul, mul_done;
  exo_t                 exo;

  logic [DBITS-1:0]     op2, res, target, jalr_sum;
  logic [4:0]           shamt;
  logic                 wr_class, is_load, is_store, taken;

  logic [DBITS-1:0]     mul_a, mul_b, mul_pc, mul_tag, mul_prod;
  logic [REGNOBITS-1:0] mul_wregno;

  // Readiness is purely state-based; a redirect cycle still accepts and drops the wrong-path op.
  assign in_ready = reset && (state == IDLE);
  assign take     = in_valid && in_ready && !br_redirect;
  assign is_mul   = (in_op == MUL_I);
  assign mul_prod = mul_a * mul_b;
  assign jalr_sum = in_rs1val + in_imm;

  always_comb begin
    op2 = in_imm;
    case (in_op)
      ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLT_I, SLTU_I,
      SLL_I, SRL_I, SRA_I, MUL_I: op2 = in_rs2val;
      default: ;
    endcase
  end

  assign shamt = op2[4:0];

  always_comb begin
    res      = in_rs1val;
    wr_class = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    taken    = 1'b0;
    target   = in_pc + in_imm;
    case (in_op)
      ADD_I, ADDI_I: begin res = in_rs1val + op2; wr_class = 1'b1; end
      SUB_I:         begin res = in_rs1val - op2; wr_class = 1'b1; end
      AND_I, ANDI_I: begin res = in_rs1val & op2; wr_class = 1'b1; end
      OR_I, ORI_I:   begin res = in_rs1val | op2; wr_class = 1'b1; end
      XOR_I, XORI_I: begin res = in_rs1val ^ op2; wr_class = 1'b1; end
      SLT_I, SLTI_I: begin
        res = {{(DBITS-1){1'b0}}, ($signed(in_rs1val) < $signed(op2))};
        wr_class = 1'b1;
      end
      SLTU_I, SLTIU_I: begin
        res = {{(DBITS-1){1'b0}}, (in_rs1val < op2)};
        wr_class = 1'b1;
      end
      SLL_I, SLLI_I: begin res = in_rs1val << shamt; wr_class = 1'b1; end
      SRL_I, SRLI_I: begin res = in_rs1val >> shamt; wr_class = 1'b1; end
      SRA_I, SRAI_I: begin res = $unsigned($signed(in_rs1val) >>> shamt); wr_class = 1'b1; end
      LUI_I:   begin res = in_imm; wr_class = 1'b1; end
      AUIPC_I: begin res = in_pc + in_imm; wr_class = 1'b1; end
      LW_I:    begin res = in_rs1val + in_imm; wr_class = 1'b1; is_load = 1'b1; end
      SW_I:    begin res = in_rs1val + in_imm; is_store = 1'b1; end
      JAL_I:   begin res = in_pcplus; wr_class = 1'b1; taken = 1'b1; end
      JALR_I: begin
        res      = in_pcplus;
        wr_class = 1'b1;
        taken    = 1'b1;
        target   = {jalr_sum[DBITS-1:1], 1'b0};
      end
      BEQ_I:   taken = (in_rs1val == in_rs2val);
      BNE_I:   taken = (in_rs1val != in_rs2val);
      BLT_I:   taken = ($signed(in_rs1val) < $signed(in_rs2val));
      BGE_I:   taken = ($signed(in_rs1val) >= $signed(in_rs2val));
      BLTU_I:  taken = (in_rs1val < in_rs2val);
      BGEU_I:  taken = (in_rs1val >= in_rs2val);
      MUL_I:   wr_class = 1'b1;
      CSRR_I:  wr_class = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Busy for MUL_CYCLES-1 cycles; the product lands on the edge that leaves MUL_BUSY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mul_done  = 1'b0;
    case (state)
      IDLE: begin
        if (take && is_mul) begin
          state_nxt = MUL_BUSY;
          cnt_nxt   = '0;
        end
      end
      MUL_BUSY: begin
        if (cnt == CNTW'(MUL_CYCLES - 2)) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      exo         <= '0;
      br_redirect <= 1'b0;
      br_target   <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_pc      <= '0;
      mul_tag     <= '0;
      mul_wregno  <= '0;
    end else begin
      br_redirect <= take && taken;
      if (take && taken)
        br_target <= target;

      if (take && is_mul) begin
        mul_a      <= in_rs1val;
        mul_b      <= op2;
        mul_pc     <= in_pc;
        mul_tag    <= in_inst_count;
        mul_wregno <= in_wregno;
      end

      if (mul_done) begin
        exo.valid      <= 1'b1;
        exo.result     <= mul_prod;
        exo.st_data    <= '0;
        exo.wregno     <= mul_wregno;
        exo.wr_reg     <= (mul_wregno != '0);
        exo.is_load    <= 1'b0;
        exo.is_store   <= 1'b0;
        exo.pc         <= mul_pc;
        exo.inst_count <= mul_tag;
      end else if (take && !is_mul) begin
        exo.valid      <= 1'b1;
        exo.result     <= res;
        exo.st_data    <= in_rs2val;
        exo.wregno     <= in_wregno;
        exo.wr_reg     <= wr_class && (in_wregno != '0);
        exo.is_load    <= is_load;
        exo.is_store   <= is_store;
        exo.pc         <= in_pc;
        exo.inst_count <= in_inst_count;
      end else begin
        exo.valid <= 1'b0;
      end
    end
  end

  assign out_valid      = exo.valid;
  assign out_result     = exo.result;
  assign out_st_data    = exo.st_data;
  assign out_wregno     = exo.wregno;
  assign out_wr_reg     = exo.wr_reg;
  assign out_is_load    = exo.is_load;
  assign out_is_store   = exo.is_store;
  assign out_pc         = exo.pc;
  assign out_inst_count = exo.inst_count;

endmodule

// File: tb/tb_agex_stage.sv
// Directed bench for agex_stage: vector table for single-cycle ops, hand sequences for squash, MUL and reset.
module tb_agex_stage;
  import agex_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_pc, in_pcplus, in_rs1val, in_rs2val, in_imm, in_inst_count;
  logic [4:0]  in_wregno;
  logic        out_valid, out_wr_reg, out_is_load, out_is_store, br_redirect;
  logic [31:0] out_result, out_st_data, out_pc, out_inst_count, br_target;
  logic [4:0]  out_wregno;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] tag = 32'h100;

  agex_stage #(.DBITS(32), .REGNOBITS(5), .IOPBITS(6), .MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_pc(in_pc), .in_pcplus(in_pcplus), .in_rs1val(in_rs1val), .in_rs2val(in_rs2val),
    .in_imm(in_imm), .in_wregno(in_wregno), .in_inst_count(in_inst_count),
    .out_valid(out_valid), .out_result(out_result), .out_st_data(out_st_data),
    .out_wregno(out_wregno), .out_wr_reg(out_wr_reg), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_pc(out_pc), .out_inst_count(out_inst_count),
    .br_redirect(br_redirect), .br_target(br_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  w;
    logic        chk_res;
    logic [31:0] exp_res;
    logic        exp_wr, exp_ld, exp_st, exp_redir;
    logic [31:0] exp_tgt;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] w);
    in_op         = op;
    in_pc         = pc;
    in_pcplus     = pc + 32'd4;
    in_rs1val     = rs1;
    in_rs2val     = rs2;
    in_imm        = imm;
    in_wregno     = w;
    tag           = tag + 32'd1;
    in_inst_count = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] t1;

    //            name      op       pc        rs1           rs2           imm           w  chk  exp_res       wr ld st rd exp_tgt
    vecs[0]  = '{"add",    ADD_I,   32'h0,    32'h7FFFFFFF, 32'h1,        32'h0,        5, 1, 32'h80000000, 1, 0, 0, 0, 32'h0};
    vecs[1]  = '{"sra",    SRA_I,   32'h0,    32'h80000000, 32'h4,        32'h0,        6, 1, 32'hF8000000, 1, 0, 0, 0, 32'h0};
    vecs[2]  = '{"sltu",   SLTU_I,  32'h0,    32'h1,        32'hFFFFFFFF, 32'h0,        7, 1, 32'h1,        1, 0, 0, 0, 32'h0};
    vecs[3]  = '{"slt",    SLT_I,   32'h0,    32'hFFFFFFFF, 32'h1,        32'h0,        8, 1, 32'h1,        1, 0, 0, 0, 32'h0};
    vecs[4]  = '{"sub",    SUB_I,   32'h0,    32'h5,        32'h7,        32'h0,        9, 1, 32'hFFFFFFFE, 1, 0, 0, 0, 32'h0};
    vecs[5]  = '{"srli",   SRLI_I,  32'h0,    32'h80000000, 32'h0,        32'h24,       10, 1, 32'h08000000, 1, 0, 0, 0, 32'h0};
    vecs[6]  = '{"lui",    LUI_I,   32'h0,    32'h0,        32'h0,        32'h12345000, 11, 1, 32'h12345000, 1, 0, 0, 0, 32'h0};
    vecs[7]  = '{"auipc",  AUIPC_I, 32'h400,  32'h0,        32'h0,        32'h1000,     12, 1, 32'h1400,     1, 0, 0, 0, 32'h0};
    vecs[8]  = '{"lw",     LW_I,    32'h0,    32'h1000,     32'h0,        32'hFFFFFFFC, 3, 1, 32'hFFC,      1, 1, 0, 0, 32'h0};
    vecs[9]  = '{"sw",     SW_I,    32'h0,    32'h2000,     32'hDEAD,     32'h8,        4, 0, 32'h0,        0, 0, 1, 0, 32'h0};
    vecs[10] = '{"bne_nt", BNE_I,   32'h100,  32'h3,        32'h3,        32'h20,       0, 1, 32'h3,        0, 0, 0, 0, 32'h0};
    vecs[11] = '{"blt_t",  BLT_I,   32'h300,  32'hFFFFFFFF, 32'h1,        32'hFFFFFFF0, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h2F0};
    vecs[12] = '{"bgeu_nt",BGEU_I,  32'h300,  32'h1,        32'hFFFFFFFF, 32'h40,       0, 1, 32'h1,        0, 0, 0, 0, 32'h0};
    vecs[13] = '{"jalr",   JALR_I,  32'h200,  32'h1003,     32'h0,        32'h4,        1, 1, 32'h204,      1, 0, 0, 1, 32'h1006};
    vecs[14] = '{"jal_w0", JAL_I,   32'h500,  32'h0,        32'h0,        32'h10,       0, 1, 32'h504,      0, 0, 0, 1, 32'h510};
    vecs[15] = '{"xori",   XORI_I,  32'h0,    32'hF0F0,     32'h0,        32'hFFFFFFFF, 13, 1, 32'hFFFF0F0F, 1, 0, 0, 0, 32'h0};
    vecs[16] = '{"addi_w0",ADDI_I,  32'h0,    32'h5,        32'h0,        32'h3,        0, 1, 32'h8,        0, 0, 0, 0, 32'h0};

    reset    = 1'b0;
    in_valid = 1'b0;
    drive(ADD_I, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_redirect", {31'b0, br_redirect}, 32'h0);
    chk("rst_target", br_target, 32'h0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_wr_reg", {31'b0, out_wr_reg}, 32'h0);
    step();
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].w);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk({vecs[i].name, "_valid"}, {31'b0, out_valid}, 32'h1);
      if (vecs[i].chk_res)
        chk({vecs[i].name, "_result"}, out_result, vecs[i].exp_res);
      chk({vecs[i].name, "_wr_reg"}, {31'b0, out_wr_reg}, {31'b0, vecs[i].exp_wr});
      chk({vecs[i].name, "_wregno"}, {27'b0, out_wregno}, {27'b0, vecs[i].w});
      chk({vecs[i].name, "_is_load"}, {31'b0, out_is_load}, {31'b0, vecs[i].exp_ld});
      chk({vecs[i].name, "_is_store"}, {31'b0, out_is_store}, {31'b0, vecs[i].exp_st});
      chk({vecs[i].name, "_st_data"}, out_st_data, vecs[i].rs2);
      chk({vecs[i].name, "_pc"}, out_pc, vecs[i].pc);
      chk({vecs[i].name, "_tag"}, out_inst_count, tag);
      chk({vecs[i].name, "_redirect"}, {31'b0, br_redirect}, {31'b0, vecs[i].exp_redir});
      if (vecs[i].exp_redir)
        chk({vecs[i].name, "_target"}, br_target, vecs[i].exp_tgt);
      step();
      chk({vecs[i].name, "_bubble"}, {31'b0, out_valid}, 32'h0);
      chk({vecs[i].name, "_redirect_off"}, {31'b0, br_redirect}, 32'h0);
    end

    // Taken BEQ, wrong-path ADDI offered in the redirect cycle.
    drive(BEQ_I, 32'h100, 32'h3, 32'h3, 32'h20, 5'd0);
    in_valid = 1'b1;
    step();
    drive(ADDI_I, 32'h104, 32'h1, 32'h0, 32'h1, 5'd4);
    chk("beq_redirect", {31'b0, br_redirect}, 32'h1);
    chk("beq_target", br_target, 32'h120);
    chk("beq_valid", {31'b0, out_valid}, 32'h1);
    chk("squash_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("squash_out_valid", {31'b0, out_valid}, 32'h0);
    chk("beq_redirect_once", {31'b0, br_redirect}, 32'h0);
    step();
    chk("squash_still_gone", {31'b0, out_valid}, 32'h0);

    // Back-to-back MULs.
    drive(MUL_I, 32'h600, 32'h10000, 32'h10001, 32'h0, 5'd14);
    t1 = tag;
    in_valid = 1'b1;
    step();
    drive(MUL_I, 32'h604, 32'h7, 32'h9, 32'h0, 5'd15);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("mul1_busy_rdy_c%0d", c), {31'b0, in_ready}, 32'h0);
      chk($sformatf("mul1_busy_vld_c%0d", c), {31'b0, out_valid}, 32'h0);
      step();
    end
    chk("mul1_valid", {31'b0, out_valid}, 32'h1);
    chk("mul1_result", out_result, 32'h00010000);
    chk("mul1_wregno", {27'b0, out_wregno}, 32'd14);
    chk("mul1_wr_reg", {31'b0, out_wr_reg}, 32'h1);
    chk("mul1_tag", out_inst_count, t1);
    chk("mul1_rdy_back", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      chk($sformatf("mul2_busy_rdy_c%0d", c), {31'b0, in_ready}, 32'h0);
      chk($sformatf("mul2_busy_vld_c%0d", c), {31'b0, out_valid}, 32'h0);
      step();
    end
    chk("mul2_valid", {31'b0, out_valid}, 32'h1);
    chk("mul2_result", out_result, 32'h3F);
    chk("mul2_pc", out_pc, 32'h604);
    step();
    chk("mul2_single", {31'b0, out_valid}, 32'h0);

    // Reset asserted in cycle N+2 of a MUL.
    drive(MUL_I, 32'h700, 32'h3, 32'h5, 32'h0, 5'd2);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("rst_mul_in_ready_low", {31'b0, in_ready}, 32'h0);
    step();
    reset = 1'b1;
    #1;
    chk("rst_mul_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_mul_result", out_result, 32'h0);
    chk("rst_mul_target", br_target, 32'h0);
    chk("rst_mul_in_ready", {31'b0, in_ready}, 32'h1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("rst_mul_no_result_%0d", c), {31'b0, out_valid}, 32'h0);
    end

    // Taken branch immediately followed by MUL: the MUL never starts.
    drive(BEQ_I, 32'h800, 32'h9, 32'h9, 32'h40, 5'd0);
    in_valid = 1'b1;
    step();
    drive(MUL_I, 32'h804, 32'h2, 32'h3, 32'h0, 5'd6);
    chk("br_mul_redirect", {31'b0, br_redirect}, 32'h1);
    chk("br_mul_target", br_target, 32'h840);
    step();
    in_valid = 1'b0;
    chk("br_mul_squashed", {31'b0, out_valid}, 32'h0);
    chk("br_mul_idle_rdy", {31'b0, in_ready}, 32'h1);
    step();
    chk("br_mul_idle_rdy2", {31'b0, in_ready}, 32'h1);
    chk("br_mul_no_result", {31'b0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
